// File: rtl/hh_pkg.sv
// Shared widths, the buffered entry layout and the byte-order helper used by
// both the serializer and the comparator's le2be path.
package hh_pkg;

    localparam int HASH_W         = 256;
    localparam int WORD_W         = 64;
    localparam int NONCE_W        = 32;
    localparam int WORDS_PER_HASH = 4;
    localparam int ENTRY_W        = HASH_W + NONCE_W;

    typedef struct packed {
        logic [HASH_W-1:0]  hash;
        logic [NONCE_W-1:0] nonce;
    } entry_t;

    // Byte i of the word moves to byte 7-i.
    function automatic logic [WORD_W-1:0] byteswap64(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = w[8*(7-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/hh_entry_ram.sv
// Entry storage: one synchronous write port, two asynchronous read ports so the
// word reader and the nonce reader can look at different entries at once.
module hh_entry_ram
    import hh_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  entry_t             wdata,
    input  logic [AW-1:0]      raddr_hash,
    output logic [HASH_W-1:0]  rdata_hash,
    input  logic [AW-1:0]      raddr_nonce,
    output logic [NONCE_W-1:0] rdata_nonce
);

    entry_t mem [DEPTH];

    // Write port; contents are deliberately not reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_hash  = mem[raddr_hash].hash;
    assign rdata_nonce = mem[raddr_nonce].nonce;

endmodule

// File: rtl/heavy_hash_serializer.sv
// Buffers {hash, nonce} results and serves each hash as four byte-reversed
// 64-bit words, then the matching nonce on its own strobe. Three pointers with
// wrap bits keep nptr <= hptr <= wptr; an entry is freed only when its nonce
// has been read.
module heavy_hash_serializer
    import hh_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [255:0]           in_hash,
    input  logic [31:0]            in_nonce,
    input  logic                   flush,
    input  logic                   heavy_hash_re,
    output logic [63:0]            heavy_hash_dout,
    output logic                   heavy_hash_dout_we,
    input  logic                   nonce_re,
    output logic [31:0]            nonce_dout,
    output logic                   nonce_dout_valid,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   nonce_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [1:0]  GAP_LD  = 2'(GAP_CYCLES);

    logic [AW:0]         wptr, hptr, nptr;
    logic [1:0]          widx;
    logic [1:0]          gap;
    logic                push, word_go, nonce_go;
    logic [HASH_W-1:0]   rd_hash;
    logic [NONCE_W-1:0]  rd_nonce;
    logic [WORD_W-1:0]   cur_word;
    entry_t              wr_entry;

    assign occupancy = wptr - nptr;
    // Occupancy comes from registered pointers, so a same-cycle nonce pop
    // never opens room for a write in that cycle.
    assign in_ready  = !rst && !flush && (occupancy != FULL);
    assign push      = in_valid && in_ready;
    assign word_go   = heavy_hash_re && (hptr != wptr) && (gap == 2'd0);
    assign nonce_go  = nonce_re && (nptr != hptr);
    assign cur_word  = rd_hash[WORD_W*widx +: WORD_W];

    assign wr_entry.hash  = in_hash;
    assign wr_entry.nonce = in_nonce;

    hh_entry_ram #(.DEPTH(DEPTH)) u_ram (
        .clk         (clk),
        .we          (push),
        .waddr       (wptr[AW-1:0]),
        .wdata       (wr_entry),
        .raddr_hash  (hptr[AW-1:0]),
        .rdata_hash  (rd_hash),
        .raddr_nonce (nptr[AW-1:0]),
        .rdata_nonce (rd_nonce)
    );

    // Write pointer: advances on every accepted entry.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
        end else if (push) begin
            wptr <= wptr + PTR_ONE;
        end
    end

    // Word reader: one word per granted request, then a dead gap after word 3
    // while the comparator settles its result.
    always_ff @(posedge clk) begin
        if (rst) begin
            hptr               <= '0;
            widx               <= '0;
            gap                <= '0;
            heavy_hash_dout    <= '0;
            heavy_hash_dout_we <= 1'b0;
        end else if (flush) begin
            hptr               <= '0;
            widx               <= '0;
            gap                <= '0;
            heavy_hash_dout_we <= 1'b0;
        end else begin
            heavy_hash_dout_we <= word_go;
            if (gap != 2'd0) begin
                gap <= gap - 2'd1;
            end
            if (word_go) begin
                heavy_hash_dout <= byteswap64(cur_word);
                if (widx == 2'(WORDS_PER_HASH - 1)) begin
                    widx <= '0;
                    hptr <= hptr + PTR_ONE;
                    gap  <= GAP_LD;
                end else begin
                    widx <= widx + 2'd1;
                end
            end
        end
    end

    // Nonce reader: pops only fully-sent hashes; reading ahead is flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            nptr             <= '0;
            nonce_dout       <= '0;
            nonce_dout_valid <= 1'b0;
            nonce_underflow  <= 1'b0;
        end else if (flush) begin
            nptr             <= '0;
            nonce_dout_valid <= 1'b0;
            nonce_underflow  <= 1'b0;
        end else begin
            nonce_dout_valid <= nonce_go;
            if (nonce_go) begin
                nonce_dout <= rd_nonce;
                nptr       <= nptr + PTR_ONE;
            end else if (nonce_re) begin
                nonce_underflow <= 1'b1;
            end
        end
    end

endmodule
